ip_cartbus_bridge: RTL and testbench

Parametrised MSX cartridge-slot bus bridge. It sits between the raw cartridge connector pins and an internal req/ack target such as the VDP register port or the debugger. It synchronises the asynchronous n_ce/n_trd/n_twr strobes and turns each slot access into exactly one internal request. It holds the MSX bus with twait until the target acknowledges, then drives read data back through tdir/td. It adds a configurable address width, synchroniser depth, ack timeout with a fallback read value, and a sticky error flag.

---
 rtl/ip_cartbus_bridge_if.sv | 33 +++
 rtl/ip_cartbus_bridge.sv | 144 ++++++++++++++
 tb/tb_ip_cartbus_bridge.sv | 363 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ip_cartbus_bridge_if.sv
// Signal bundle between the MSX cartridge-slot pins, the bridge and its internal req/ack target.
// The master modport is the bridge itself; slave is the environment around it.
interface ip_cartbus_bridge_if #(
  parameter int ADDR_W = 2
) ();
  logic              n_ce;
  logic              n_trd;
  logic              n_twr;
  logic [ADDR_W-1:0] ta;
  logic [7:0]        td_in;
  logic [7:0]        td_out;
  logic              td_oe;
  logic              tdir;
  logic              twait;
  logic              req;
  logic              ack;
  logic              wr;
  logic [ADDR_W-1:0] address;
  logic [7:0]        wdata;
  logic [7:0]        rdata;
  logic              busy;
  logic              timeout_err;

  modport master (
    input  n_ce, n_trd, n_twr, ta, td_in, ack, rdata,
    output td_out, td_oe, tdir, twait, req, wr, address, wdata, busy, timeout_err
  );

  modport slave (
    output n_ce, n_trd, n_twr, ta, td_in, ack, rdata,
    input  td_out, td_oe, tdir, twait, req, wr, address, wdata, busy, timeout_err
  );
endinterface

// File: rtl/ip_cartbus_bridge.sv
// MSX cartridge-slot to internal req/ack bridge: synchronises the slot strobes, issues one
// request per access, stretches the MSX cycle with twait and drives read data back on td.
module ip_cartbus_bridge #(
  parameter int         ADDR_W      = 2,
  parameter int         SYNC_STAGES = 2,
  parameter int         TIMEOUT     = 255,
  parameter int         TIMEOUT_W   = 8,
  parameter logic [7:0] IDLE_DATA   = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  ip_cartbus_bridge_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, RDRIVE, RELEASE} state_t;

  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

  state_t                 state;
  logic [SYNC_STAGES-1:0] ce_sync, rd_sync, wr_sync;
  logic [ADDR_W-1:0]      ta_sync [SYNC_STAGES];
  logic [7:0]             td_sync [SYNC_STAGES];

  logic                   s_ce, s_rd, s_wr;
  logic [ADDR_W-1:0]      s_ta;
  logic [7:0]             s_td;
  logic                   active, conflict, act_prev, act_rise;
  logic [TIMEOUT_W-1:0]   cnt;

  logic                   req_r, wr_r, td_oe_r, twait_r, busy_r, err_r;
  logic [ADDR_W-1:0]      address_r;
  logic [7:0]             wdata_r, td_out_r;

  // Synchroniser chains; left unreset so they reflect the pins as soon as reset is released.
  always_ff @(posedge clk) begin
    ce_sync    <= {ce_sync[SYNC_STAGES-2:0], ~bus.n_ce};
    rd_sync    <= {rd_sync[SYNC_STAGES-2:0], ~bus.n_trd};
    wr_sync    <= {wr_sync[SYNC_STAGES-2:0], ~bus.n_twr};
    ta_sync[0] <= bus.ta;
    td_sync[0] <= bus.td_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      ta_sync[i] <= ta_sync[i-1];
      td_sync[i] <= td_sync[i-1];
    end
  end

  assign s_ce = ce_sync[SYNC_STAGES-1];
  assign s_rd = rd_sync[SYNC_STAGES-1];
  assign s_wr = wr_sync[SYNC_STAGES-1];
  assign s_ta = ta_sync[SYNC_STAGES-1];
  assign s_td = td_sync[SYNC_STAGES-1];

  // Both strobes low counts as "still busy" in the history so that releasing only one of
  // them cannot look like a fresh access.
  assign active   = s_ce & (s_rd ^ s_wr);
  assign conflict = s_ce & s_rd & s_wr;
  assign act_rise = active & ~act_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      act_prev  <= 1'b1;
      cnt       <= '0;
      req_r     <= 1'b0;
      wr_r      <= 1'b0;
      address_r <= '0;
      wdata_r   <= '0;
      td_out_r  <= '0;
      td_oe_r   <= 1'b0;
      twait_r   <= 1'b0;
      busy_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      act_prev <= active | conflict;
      case (state)
        IDLE: begin
          if (act_rise) begin
            address_r <= s_ta;
            wr_r      <= s_wr;
            wdata_r   <= s_td;
            req_r     <= 1'b1;
            twait_r   <= 1'b1;
            busy_r    <= 1'b1;
            cnt       <= '0;
            state     <= REQ;
          end
        end
        REQ: begin
          if (bus.ack) begin
            req_r   <= 1'b0;
            twait_r <= 1'b0;
            if (!wr_r) begin
              td_out_r <= bus.rdata;
              td_oe_r  <= 1'b1;
              state    <= RDRIVE;
            end else begin
              state <= RELEASE;
            end
          end else if (cnt == CNT_LAST) begin
            // Target never answered: free the MSX bus, reads see IDLE_DATA, writes are lost.
            req_r   <= 1'b0;
            twait_r <= 1'b0;
            err_r   <= 1'b1;
            if (!wr_r) begin
              td_out_r <= IDLE_DATA;
              td_oe_r  <= 1'b1;
              state    <= RDRIVE;
            end else begin
              state <= RELEASE;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RDRIVE: begin
          if (!s_ce || !s_rd) begin
            td_oe_r <= 1'b0;
            busy_r  <= 1'b0;
            state   <= IDLE;
          end
        end
        RELEASE: begin
          if (!active) begin
            busy_r <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req         = req_r;
  assign bus.wr          = wr_r;
  assign bus.address     = address_r;
  assign bus.wdata       = wdata_r;
  assign bus.td_out      = td_out_r;
  assign bus.td_oe       = td_oe_r;
  assign bus.tdir        = td_oe_r;
  assign bus.twait       = twait_r;
  assign bus.busy        = busy_r;
  assign bus.timeout_err = err_r;

endmodule

// File: tb/tb_ip_cartbus_bridge.sv
// Bench for ip_cartbus_bridge: randomized slot accesses, expected requests and read data
// queued by the stimulus and matched by an independent monitor.
module tb_ip_cartbus_bridge;

  localparam int ADDR_W = 2;
  localparam int SYNC   = 2;
  localparam int TMO    = 8;

  typedef struct {
    bit         wr;
    logic [1:0] addr;
    logic [7:0] data;
    int         len;
  } req_t;

  logic clk = 1'b0;
  logic reset;

  ip_cartbus_bridge_if #(.ADDR_W(ADDR_W)) bus ();

  ip_cartbus_bridge #(
    .ADDR_W(ADDR_W), .SYNC_STAGES(SYNC), .TIMEOUT(TMO), .TIMEOUT_W(8), .IDLE_DATA(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial forever #5 clk = ~clk;

  req_t       req_q [$];
  logic [7:0] rd_q  [$];
  int         checks = 0;
  int         failures = 0;
  int         pulses = 0;
  int         exp_pulses = 0;
  bit         exp_err = 1'b0;
  int         ack_mode = 2;   // 0: ack after ack_dly cycles, 1: tied high, 2: never
  int         ack_dly = 1;
  int         rcnt = 0;

  bit         mon_req_d = 1'b0;
  bit         mon_oe_d = 1'b0;
  int         mon_len = 0;
  req_t       mon_cur;

  bit         r_w;
  int         r_mode, r_dly, r_hold;
  logic [1:0] r_a;
  logic [7:0] r_d, r_rd;
  bit         seen;
  req_t       it;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_req"}, bus.req, 0);
    chk({tag, "_wr"}, bus.wr, 0);
    chk({tag, "_address"}, bus.address, 0);
    chk({tag, "_wdata"}, bus.wdata, 0);
    chk({tag, "_td_out"}, bus.td_out, 0);
    chk({tag, "_td_oe"}, bus.td_oe, 0);
    chk({tag, "_tdir"}, bus.tdir, 0);
    chk({tag, "_twait"}, bus.twait, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_timeout_err"}, bus.timeout_err, 0);
  endtask

  // Target model: acknowledges each request after a programmable number of cycles.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (ack_mode == 1) bus.ack = 1'b1;
      else if (ack_mode == 2) begin
        bus.ack = 1'b0;
        rcnt = 0;
      end else if (bus.ack) begin
        bus.ack = 1'b0;
        rcnt = 0;
      end else if (bus.req) begin
        rcnt++;
        if (rcnt >= ack_dly) begin
          bus.ack = 1'b1;
          rcnt = 0;
        end
      end else rcnt = 0;
    end
  end

  // Monitor: matches every request and every read-data drive against the queued expectations.
  initial begin
    mon_cur = '{wr: 1'b0, addr: 2'b00, data: 8'h00, len: 0};
    forever begin
      @(negedge clk);
      chk("twait_eq_req", bus.twait, bus.req);
      chk("tdir_eq_td_oe", bus.tdir, bus.td_oe);
      if (bus.req) chk("busy_during_req", bus.busy, 1);
      if (bus.req && !mon_req_d) begin
        pulses++;
        if (req_q.size() == 0) begin
          chk("unexpected_req", bus.req, 0);
          mon_cur.len = 0;
        end else begin
          mon_cur = req_q.pop_front();
          chk("req_wr", bus.wr, mon_cur.wr);
          chk("req_address", bus.address, mon_cur.addr);
          if (mon_cur.wr) chk("req_wdata", bus.wdata, mon_cur.data);
        end
        mon_len = 1;
      end else if (bus.req) begin
        mon_len++;
        chk("address_stable", bus.address, mon_cur.addr);
        chk("wr_stable", bus.wr, mon_cur.wr);
      end else if (mon_req_d && mon_cur.len != 0) begin
        chk("req_length", mon_len, mon_cur.len);
      end
      if (bus.td_oe && !mon_oe_d) begin
        if (rd_q.size() == 0) chk("unexpected_td_oe", bus.td_oe, 0);
        else chk("td_out", bus.td_out, rd_q.pop_front());
      end
      mon_req_d = bus.req;
      mon_oe_d  = bus.td_oe;
    end
  end

  // One complete MSX slot access as the Z80 would perform it.
  task automatic do_access(input bit w, input logic [1:0] a, input logic [7:0] d,
                           input logic [7:0] rd, input int mode, input int dly, input int hold);
    req_t t;
    int   lat;
    bit   ok;
    ack_mode = mode;
    ack_dly  = dly;
    t.wr   = w;
    t.addr = a;
    t.data = d;
    t.len  = (mode == 1) ? 1 : (mode == 2) ? TMO : dly;
    req_q.push_back(t);
    exp_pulses++;
    if (!w) rd_q.push_back((mode == 2) ? 8'hFF : rd);
    bus.rdata = rd;
    @(negedge clk);
    #1;
    bus.ta    = a;
    bus.td_in = w ? d : 8'($urandom);
    bus.n_ce  = 1'b0;
    if (w) bus.n_twr = 1'b0;
    else   bus.n_trd = 1'b0;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req) begin
        ok = 1'b1;
        break;
      end
      lat++;
    end
    chk("req_seen", ok, 1);
    chk("start_latency", lat, SYNC);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!bus.twait) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("twait_released", ok, 1);
    chk("td_oe_after_ack", bus.td_oe, !w);
    repeat (hold) @(negedge clk);
    #1;
    bus.n_ce  = 1'b1;
    bus.n_trd = 1'b1;
    bus.n_twr = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!bus.td_oe) break;
      lat++;
    end
    if (!w) chk("release_latency", lat, SYNC);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_after_release", ok, 1);
    if (mode == 2) exp_err = 1'b1;
    chk("timeout_err", bus.timeout_err, exp_err);
    chk("pulse_count", pulses, exp_pulses);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.n_ce  = 1'b1;
    bus.n_trd = 1'b1;
    bus.n_twr = 1'b1;
    bus.ta    = '0;
    bus.td_in = '0;
    bus.ack   = 1'b0;
    bus.rdata = '0;
    reset     = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_vals("por");
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);

    // Directed read and write
    do_access(1'b0, 2'b01, 8'h00, 8'h5A, 0, 3, 2);
    do_access(1'b1, 2'b10, 8'hC3, 8'h00, 0, 2, 2);

    // Long strobe with ack tied high, then a second access
    do_access(1'b0, 2'b11, 8'h00, 8'h33, 1, 1, 100);
    do_access(1'b1, 2'b00, 8'h81, 8'h00, 1, 1, 3);

    // Target never answers: read returns 8'hFF, write is dropped, error stays set
    do_access(1'b0, 2'b10, 8'h00, 8'h12, 2, 1, 4);
    do_access(1'b1, 2'b01, 8'h44, 8'h00, 2, 1, 2);

    for (int n = 0; n < 25; n++) begin
      r_w    = 1'($urandom_range(0, 1));
      r_a    = 2'($urandom);
      r_d    = 8'($urandom);
      r_rd   = 8'($urandom);
      r_mode = ($urandom_range(0, 5) == 0) ? 1 : 0;
      r_dly  = $urandom_range(1, 5);
      r_hold = $urandom_range(0, 4);
      do_access(r_w, r_a, r_d, r_rd, r_mode, r_dly, r_hold);
    end

    // Both strobes low together, then only one released: never an access
    ack_mode = 0;
    ack_dly  = 1;
    @(negedge clk);
    #1;
    bus.n_ce  = 1'b0;
    bus.n_trd = 1'b0;
    bus.n_twr = 1'b0;
    repeat (20) @(negedge clk);
    chk("conflict_twait", bus.twait, 0);
    chk("conflict_busy", bus.busy, 0);
    #1 bus.n_twr = 1'b1;
    repeat (10) @(negedge clk);
    chk("conflict_half_release_busy", bus.busy, 0);
    chk("conflict_pulses", pulses, exp_pulses);
    #1;
    bus.n_ce  = 1'b1;
    bus.n_trd = 1'b1;
    repeat (5) @(negedge clk);

    // n_ce glitch straddling one clock edge while n_trd is low: one short read access
    ack_mode  = 0;
    ack_dly   = 2;
    bus.rdata = 8'hA7;
    bus.ta    = 2'b11;
    it = '{wr: 1'b0, addr: 2'b11, data: 8'h00, len: 2};
    req_q.push_back(it);
    rd_q.push_back(8'hA7);
    exp_pulses++;
    @(negedge clk);
    #1 bus.n_trd = 1'b0;
    repeat (3) @(negedge clk);
    #4 bus.n_ce = 1'b0;
    #2 bus.n_ce = 1'b1;
    repeat (15) @(negedge clk);
    chk("glitch_pulses", pulses, exp_pulses);
    chk("glitch_idle", bus.busy, 0);
    #1 bus.n_trd = 1'b1;
    repeat (4) @(negedge clk);

    // Reset while waiting for ack; the still-low strobe must not restart an access
    ack_mode = 2;
    bus.ta   = 2'b01;
    it = '{wr: 1'b0, addr: 2'b01, data: 8'h00, len: 0};
    req_q.push_back(it);
    exp_pulses++;
    @(negedge clk);
    #1;
    bus.n_ce  = 1'b0;
    bus.n_trd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_req_seen", seen, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_in_req");
    exp_err = 1'b0;
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_req_no_new_req", pulses, exp_pulses);
    chk("rst_req_busy", bus.busy, 0);
    #1;
    bus.n_ce  = 1'b1;
    bus.n_trd = 1'b1;
    repeat (4) @(negedge clk);

    // Reset while driving read data
    ack_mode  = 0;
    ack_dly   = 1;
    bus.rdata = 8'h6C;
    bus.ta    = 2'b10;
    it = '{wr: 1'b0, addr: 2'b10, data: 8'h00, len: 1};
    req_q.push_back(it);
    rd_q.push_back(8'h6C);
    exp_pulses++;
    @(negedge clk);
    #1;
    bus.n_ce  = 1'b0;
    bus.n_trd = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.td_oe) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_rdrive_seen", seen, 1);
    #1 reset = 1'b1;
    @(negedge clk);
    check_reset_vals("rst_in_rdrive");
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_rdrive_no_new_req", pulses, exp_pulses);
    chk("rst_rdrive_busy", bus.busy, 0);
    #1;
    bus.n_ce  = 1'b1;
    bus.n_trd = 1'b1;
    repeat (4) @(negedge clk);

    // A fresh access still works after the resets
    do_access(1'b0, 2'b11, 8'h00, 8'h9E, 0, 2, 1);

    chk("req_queue_drained", req_q.size(), 0);
    chk("rd_queue_drained", rd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
